// File: rtl/pdm_audio_cic_if.sv
// PCM sample handshake between the CIC decimator and its consumer.
// master = decimator, slave = CPU/FIFO side.
interface pdm_audio_cic_if #(
  parameter int OUT_WIDTH = 16
);
  logic signed [OUT_WIDTH-1:0] o_sample;
  logic                        o_valid;
  logic                        i_ready;

  modport master (
    output o_sample,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_sample,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/pdm_audio_cic.sv
// PDM microphone to PCM: 3rd-order CIC decimator with valid/ready out.
// Optional gain stage: define PDM_AUDIO_CIC_GAIN_EN to add i_gain[1:0].
module pdm_audio_cic #(
  parameter int DECIM      = 64,
  parameter int LOG2_DECIM = 6,
  parameter int OUT_WIDTH  = 16
) (
  input  logic i_hf_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_pdm_clk,
  input  logic i_pdm_data,
  input  logic i_edge_sel,
`ifdef PDM_AUDIO_CIC_GAIN_EN
  input  logic [1:0] i_gain,
`endif
  input  logic i_clear_overrun,
  output logic o_overrun,
  pdm_audio_cic_if.master pcm
);

  localparam int W  = 3*LOG2_DECIM+2;
  localparam int S  = 3*LOG2_DECIM+1-OUT_WIDTH;
  localparam int GW = W+3;
  localparam logic signed [GW-1:0] SMAX =
    GW'(2**(OUT_WIDTH-1)-1);
  localparam logic signed [GW-1:0] SMIN =
    GW'(-(2**(OUT_WIDTH-1)));
  localparam logic [LOG2_DECIM-1:0] CLAST =
    LOG2_DECIM'(DECIM-1);

  logic clk_d;
  logic sync1;
  logic sync2;
  logic strobe;
  logic wrap;
  logic [LOG2_DECIM-1:0] cnt;
  logic fe_q;
  logic cv_q;
  logic [1:0] gain_q;

  logic signed [W-1:0] in_val;
  logic signed [W-1:0] int1, int2, int3;
  logic signed [W-1:0] i1n, i2n, i3n;
  logic signed [W-1:0] z1, z2, z3;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] comb_q;
  logic signed [W-1:0] sh;
  logic signed [GW-1:0] ext;
  logic signed [GW-1:0] gs;
  logic signed [OUT_WIDTH-1:0] fmt;
  logic ovr_set;

  assign strobe = i_enable &&
    (i_edge_sel ? (clk_d && !i_pdm_clk)
                : (!clk_d && i_pdm_clk));
  assign wrap   = strobe && (cnt == CLAST);
  assign in_val = sync2 ? W'(1) : {W{1'b1}};

  assign i1n = int1 + in_val;
  assign i2n = int2 + i1n;
  assign i3n = int3 + i2n;

  assign d1 = int3 - z1;
  assign d2 = d1 - z2;
  assign d3 = d2 - z3;

  // PDM clock delay for edge detect; tracks even while disabled
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset) clk_d <= 1'b0;
    else         clk_d <= i_pdm_clk;
  end

  // two-flop synchronizer for the asynchronous pad data
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else if (!i_enable) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_pdm_data;
      sync2 <= sync1;
    end
  end

  // integrator cascade and decimation counter at the PDM rate
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      cnt  <= '0;
      fe_q <= 1'b0;
    end else if (!i_enable) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      cnt  <= '0;
      fe_q <= 1'b0;
    end else begin
      fe_q <= wrap;
      if (strobe) begin
        int1 <= i1n;
        int2 <= i2n;
        int3 <= i3n;
        cnt  <= cnt + 1'b1;
      end
    end
  end

`ifdef PDM_AUDIO_CIC_GAIN_EN
  // gain is latched with the frame it applies to
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset)   gain_q <= 2'd0;
    else if (wrap) gain_q <= i_gain;
  end
`else
  assign gain_q = 2'd0;
`endif

  // comb cascade, all three stages step together per frame
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset) begin
      z1     <= '0;
      z2     <= '0;
      z3     <= '0;
      comb_q <= '0;
      cv_q   <= 1'b0;
    end else if (!i_enable) begin
      z1     <= '0;
      z2     <= '0;
      z3     <= '0;
      comb_q <= '0;
      cv_q   <= 1'b0;
    end else begin
      cv_q <= fe_q;
      if (fe_q) begin
        z1     <= int3;
        z2     <= d1;
        z3     <= d2;
        comb_q <= d3;
      end
    end
  end

  assign sh  = comb_q >>> S;
  assign ext = {{3{sh[W-1]}}, sh};
  assign gs  = ext <<< gain_q;

  // scale down, apply gain, clamp to the PCM range
  always_comb begin
    fmt = gs[OUT_WIDTH-1:0];
    if (gs > SMAX)      fmt = SMAX[OUT_WIDTH-1:0];
    else if (gs < SMIN) fmt = SMIN[OUT_WIDTH-1:0];
  end

  assign ovr_set = i_enable && cv_q &&
                   pcm.o_valid && !pcm.i_ready;

  // output register with handshake; new sample beats accept
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset) begin
      pcm.o_sample <= '0;
      pcm.o_valid  <= 1'b0;
    end else if (!i_enable) begin
      pcm.o_valid  <= 1'b0;
    end else if (cv_q) begin
      pcm.o_sample <= fmt;
      pcm.o_valid  <= 1'b1;
    end else if (pcm.o_valid && pcm.i_ready) begin
      pcm.o_valid  <= 1'b0;
    end
  end

  // sticky overrun flag; a set beats a same-cycle clear
  always_ff @(posedge i_hf_clock or posedge i_reset) begin
    if (i_reset)              o_overrun <= 1'b0;
    else if (ovr_set)         o_overrun <= 1'b1;
    else if (i_clear_overrun) o_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_pdm_audio_cic.sv
// Bench for pdm_audio_cic: FIR-kernel reference model of the CIC,
// per-cycle output compare, plus literal settled-value checks.
module tb_pdm_audio_cic;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic pclk = 1'b0;
  logic pdata = 1'b0;
  logic sel = 1'b0;
  logic clr = 1'b0;
  logic [1:0] gain_s = 2'd0;
  logic ovr;

  pdm_audio_cic_if #(.OUT_WIDTH(16)) pcm();

  pdm_audio_cic dut (
    .i_hf_clock      (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_pdm_clk       (pclk),
    .i_pdm_data      (pdata),
    .i_edge_sel      (sel),
`ifdef PDM_AUDIO_CIC_GAIN_EN
    .i_gain          (gain_s),
`endif
    .i_clear_overrun (clr),
    .o_overrun       (ovr),
    .pcm             (pcm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int val;
  } pend_t;

  int tests = 0;
  int fails = 0;
  int h[190];
  int xs[$];
  pend_t pend[$];
  bit m_valid, m_ovr, m_loaded;
  int m_sample;
  bit p_prev, e1, e2, d1, d2;
  int cyc = 0;
  int md = 0;
  int rdy_pct = 100;
  int clr_pct = 0;
  bit clr_force = 0;
  bit rst_drv = 1;
  bit en_drv = 0;
  bit sel_drv = 0;
  bit rbit = 0;
  bit lit_on = 0;
  int lit = 0;
  int nsamp = 0;
  bit meas = 0;
  int first_s = -1;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // CIC response = (64-tap boxcar)^3 applied to the +/-1 stream
  function automatic void build_h();
    int t[127];
    for (int i = 0; i < 127; i++) t[i] = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) t[i+j] += 1;
    for (int i = 0; i < 190; i++) h[i] = 0;
    for (int i = 0; i < 127; i++)
      for (int j = 0; j < 64; j++) h[i+j] += t[i];
  endfunction

  function automatic int fir();
    int n = xs.size() - 1;
    int acc = 0;
    for (int k = 0; k < 190; k++)
      if (n - k >= 0) acc += h[k] * xs[n-k];
    return acc;
  endfunction

  function automatic int fmt(int r, int g);
    int s = r >>> 3;
    s = s <<< g;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    xs.delete();
    pend.delete();
    m_valid = 0;
    m_ovr = 0;
    m_loaded = 0;
    m_sample = 0;
    p_prev = 0;
    e1 = 0;
    e2 = 0;
    d1 = 0;
    d2 = 0;
  endtask

  task automatic sample_chk();
    @(posedge clk);
    #1;
    chk("valid", int'(pcm.o_valid), int'(m_valid));
    chk("sample", int'(pcm.o_sample), m_sample);
    chk("overrun", int'(ovr), int'(m_ovr));
    if (m_loaded && lit_on) begin
      nsamp++;
      if (nsamp >= 3)
        chk("settled", int'(pcm.o_sample), lit);
    end
  endtask

  task automatic drive_upd();
    bit strobe, ld, set;
    int bitv;
    pend_t p;
    pclk = cyc[1];
    if (cyc % 4 == 0) rbit = 1'($urandom_range(0, 1));
    case (md)
      0: pdata = 1'b1;
      1: pdata = 1'b0;
      2: pdata = 1'((cyc / 4) % 2);
      3: pdata = ((cyc / 4) % 4 == 0);
      default: pdata = rbit;
    endcase
    pcm.i_ready = ($urandom_range(1, 100) <= rdy_pct);
    clr = clr_force || ($urandom_range(1, 100) <= clr_pct);
    sel = sel_drv;
    en = en_drv;
    rst = rst_drv;
    if (rst_drv) begin
      #1;
      chk("rst_valid", int'(pcm.o_valid), 0);
      chk("rst_sample", int'(pcm.o_sample), 0);
      chk("rst_overrun", int'(ovr), 0);
      model_reset();
      cyc++;
      return;
    end
    strobe = en && (sel ? (p_prev && !pclk)
                        : (!p_prev && pclk));
    bitv = (e1 && e2) ? int'(d2) : 0;
    ld = 0;
    if (!en) begin
      pend.delete();
      xs.delete();
    end else if (pend.size() > 0 && pend[0].at == cyc + 1) begin
      ld = 1;
      p = pend.pop_front();
    end
    set = ld && m_valid && !pcm.i_ready;
    if (!en) m_valid = 0;
    else if (ld) begin
      m_valid = 1;
      m_sample = p.val;
    end else if (m_valid && pcm.i_ready) m_valid = 0;
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_loaded = ld;
    if (strobe) begin
      xs.push_back(bitv != 0 ? 1 : -1);
      if (xs.size() % 64 == 0)
        pend.push_back('{cyc + 3, fmt(fir(), int'(gain_s))});
      if (meas && first_s < 0) first_s = cyc;
    end
    d2 = d1;
    d1 = pdata;
    e2 = e1;
    e1 = en;
    p_prev = pclk;
    cyc++;
  endtask

  task automatic step();
    sample_chk();
    drive_upd();
  endtask

  task automatic phase(int m, bit s, int rp, int cp,
                       bit lo, int l, int n);
    md = m;
    rdy_pct = rp;
    clr_pct = cp;
    lit_on = 0;
    en_drv = 0;
    for (int i = 0; i < 3; i++) step();
    sel_drv = s;
    en_drv = 1;
    lit_on = lo;
    lit = l;
    nsamp = 0;
    for (int i = 0; i < n; i++) step();
    lit_on = 0;
  endtask

  initial begin
    int g;
    bit seen;
    build_h();
    chk("model_dc_gain", fir() + 0, 0);
    for (int i = 0; i < 190; i++) xs.push_back(1);
    chk("model_full_scale", fir(), 262144);
    xs.delete();
    model_reset();
    for (int i = 0; i < 4; i++) step();
    rst_drv = 0;

    phase(0, 0, 100, 0, 1, 32767, 1400);
    phase(1, 0, 100, 0, 1, -32768, 1400);
    phase(2, 0, 100, 0, 1, 0, 1400);
    phase(2, 1, 100, 0, 1, 0, 1400);
    phase(3, 0, 100, 0, 1, -16384, 1400);
`ifdef PDM_AUDIO_CIC_GAIN_EN
    gain_s = 2'd2;
    phase(3, 0, 100, 0, 1, -32768, 1400);
    gain_s = 2'd0;
`endif
    phase(4, 1, 60, 5, 0, 0, 3000);

    phase(4, 0, 0, 0, 0, 0, 700);
    g = 0;
    while (pend.size() != 0 && g < 10) begin
      step();
      g++;
    end
    sample_chk();
    chk("hold_valid", int'(pcm.o_valid), 1);
    chk("hold_overrun", int'(ovr), 1);
    clr_force = 1;
    drive_upd();
    clr_force = 0;
    sample_chk();
    chk("overrun_clear", int'(ovr), 0);
    rdy_pct = 100;
    drive_upd();
    sample_chk();
    chk("valid_drop", int'(pcm.o_valid), 0);
    drive_upd();

    phase(4, 0, 100, 0, 0, 0, 0);
    g = 0;
    while (xs.size() != 30 && g < 400) begin
      step();
      g++;
    end
    chk("strobe30_reached", xs.size(), 30);
    rst_drv = 1;
    step();
    step();
    rst_drv = 0;
    meas = 1;
    first_s = -1;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      sample_chk();
      if (pcm.o_valid) begin
        seen = 1;
        chk("first_valid_lat", cyc - first_s, 255);
      end else begin
        drive_upd();
      end
    end
    if (!seen) chk("first_valid_timeout", 400, 255);
    meas = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pdm_audio_cic.md
Name: pdm_audio_cic

Overview:
- Downstream consumer of the PDM clock pad block. Samples the microphone PDM data bit once per PDM clock period, on the i_hf_clock domain.
- Runs a 3rd-order CIC decimator and delivers signed PCM samples to the CPU/FIFO side over a valid/ready handshake.
- Intended clocking: PDM clock = i_hf_clock/4 (12 MHz -> 3 MHz), DECIM=64 -> 46.875 kS/s.

Parameters:
- DECIM, 64, decimation ratio; power of two, 16..256.
- LOG2_DECIM, 6, log2(DECIM); must match DECIM.
- OUT_WIDTH, 16, PCM output width, signed; must be <= 3*LOG2_DECIM+1.

Ports:
- i_hf_clock  in  1  system clock (12 MHz HFOSC); the only clock.
- i_reset  in  1  asynchronous active-high reset.
- i_enable  in  1  block enable; low = synchronous clear of datapath.
- i_pdm_clk  in  1  PDM clock as produced by the clock block (synchronous to i_hf_clock).
- i_pdm_data  in  1  PDM data from the pad (asynchronous).
- i_edge_sel  in  1  0 = sample on PDM clock rising edge, 1 = falling edge (L/R mic select).
- o_sample  out  OUT_WIDTH  signed PCM sample.
- o_valid  out  1  o_sample holds an unconsumed sample.
- i_ready  in  1  consumer accepts o_sample when o_valid && i_ready.
- o_overrun  out  1  sticky: a sample was overwritten before being accepted.
- i_clear_overrun  in  1  synchronous clear of o_overrun.

Behaviour:
- Reset: all registers 0. o_sample=0, o_valid=0, o_overrun=0.
- Input sync: i_pdm_data passes through a 2-flop synchronizer. i_pdm_clk is registered once (clk_d).
- Strobe: one-cycle pulse when (!clk_d && i_pdm_clk) with i_edge_sel=0, or (clk_d && !i_pdm_clk) with i_edge_sel=1. No strobe while i_enable=0.
- Input mapping: synced bit 1 -> +1, bit 0 -> -1, as a W-bit two's-complement value. W = 3*LOG2_DECIM+2 (20 at defaults).
- Integrators: 3 cascaded W-bit accumulators, updated only on strobe. They wrap modulo 2^W; wrap is intentional and must not be saturated.
- Decimation counter: LOG2_DECIM bits, increments on each strobe and wraps DECIM-1 -> 0. The strobe that wraps it marks frame end.
- Combs: 3 cascaded differentiators with delay 1 at the decimated rate. Each stage is registered and captures on the cycle after frame end (stage state chain updated in a single pipeline step).
- Output formatting: comb result r lies in [-2^(3*LOG2_DECIM), +2^(3*LOG2_DECIM)].
  - Arithmetic right shift by S = 3*LOG2_DECIM+1-OUT_WIDTH (3 at defaults).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Result is registered into o_sample.
- Latency: o_valid rises exactly 3 i_hf_clock cycles after the frame-end strobe.
- Handshake:
  - o_valid stays high until o_valid && i_ready, then drops next cycle unless a new sample loads in that same cycle (new sample wins, o_valid stays 1).
  - o_sample is stable while o_valid && !i_ready.
- Overrun: a new sample loading while o_valid && !i_ready overwrites o_sample and sets o_overrun.
  - o_overrun is cleared only by i_clear_overrun or reset.
  - Set and clear in the same cycle: set wins.
- i_enable low:
  - Next cycle clears integrators, combs, counter, synchronizer and o_valid.
  - o_sample holds its value; o_overrun is preserved.
  - Re-enable restarts at frame boundary 0.
  - The first 2 output samples after enable or reset are CIC transient. The 3rd sample onward is settled.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: PDM_AUDIO_CIC_GAIN_EN.
- Defined:
  - Adds input port i_gain [1:0].
  - The shifted comb value is left-shifted by i_gain (0..3) before saturation, with saturation at the OUT_WIDTH limits.
  - i_gain is sampled at frame end.
- Undefined: port absent; gain fixed at 0. Behaviour is identical to i_gain=0.

Test Plan:
- Constant i_pdm_data=1, PDM clock=hf/4, i_ready=1 -> from the 3rd output on, o_sample=32767 (0x7FFF) every 256 hf cycles.
- Constant i_pdm_data=0 -> from the 3rd output on, o_sample=-32768 (0x8000).
- Alternating 1,0 per PDM bit (50% density) -> settled o_sample=0. Same with i_edge_sel=1: o_valid timing shifts by 2 hf cycles and values are unchanged.
- i_ready held 0 across two frame ends -> o_valid stays 1, o_sample = second sample, o_overrun=1. Pulse i_clear_overrun -> o_overrun=0. Assert i_ready -> o_valid=0 next cycle.
- Assert i_reset mid-frame (strobe 30 of 64), then release and enable -> outputs 0 immediately. The first o_valid after release comes 64 strobes + 3 cycles after the first post-reset strobe.
- With PDM_AUDIO_CIC_GAIN_EN, i_gain=2, 25% ones density -> settled o_sample saturates to -32768. With i_gain=0 -> -16384.
